// File: rtl/axi_read_arbiter_pkg.sv
// Shared types and constants for the AXI read arbiter.
// Holds the per-port FSM state encoding and the fixed AXI codes.
package axi_read_arbiter_pkg;

  localparam int MAX_PORTS = 8;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } port_state_t;

endpackage

// File: rtl/axi_read_arbiter_rr.sv
// Round-robin arbiter: one-hot grant among req, searching from last+1.
// Ports: clock, reset, req[N], advance (commit grant to pointer), grant[N].
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] last;
  logic [PW-1:0] gidx;
  logic          found;

  // Outer loop walks the search order, inner loop matches the
  // slot to a constant index so every select stays static.
  always_comb begin
    grant = '0;
    gidx  = last;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && req[i] &&
            ((int'(last) + k) % N) == i) begin
          grant[i] = 1'b1;
          gidx     = PW'(i);
          found    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last <= PW'(N - 1);
    end else if (advance && found) begin
      last <= gidx;
    end
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Multi-port AXI read arbiter: N requesters share one AR/R master port.
// Ports: clock/reset, per-port req_* and resp_* handshakes, AXI AR/R
// master channels, err_pulse/err_port for dropped or malformed beats.
module axi_read_arbiter
  import axi_read_arbiter_pkg::*;
#(
  parameter int N_PORTS = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N_PORTS-1:0]        req_valid,
  output logic [N_PORTS-1:0]        req_ready,
  input  logic [N_PORTS*ADDR_W-1:0] req_addr,
  input  logic [N_PORTS*4-1:0]      req_len,
  input  logic [N_PORTS*3-1:0]      req_size,
  output logic [N_PORTS-1:0]        resp_valid,
  input  logic [N_PORTS-1:0]        resp_ready,
  output logic [DATA_W-1:0]         resp_data,
  output logic                      resp_last,
  output logic [ID_W-1:0]           arid,
  output logic [ADDR_W-1:0]         araddr,
  output logic [3:0]                arlen,
  output logic [2:0]                arsize,
  output logic [1:0]                arburst,
  output logic [1:0]                arlock,
  output logic [3:0]                arcache,
  output logic [2:0]                arprot,
  output logic                      arvalid,
  input  logic                      arready,
  input  logic [ID_W-1:0]           rid,
  input  logic [DATA_W-1:0]         rdata,
  input  logic [1:0]                rresp,
  input  logic                      rlast,
  input  logic                      rvalid,
  output logic                      rready,
  output logic                      err_pulse,
  output logic [ID_W-1:0]           err_port
);

  port_state_t       state    [N_PORTS];
  logic [ADDR_W-1:0] lat_addr [N_PORTS];
  logic [3:0]        lat_len  [N_PORTS];
  logic [2:0]        lat_size [N_PORTS];
  logic [3:0]        beat_cnt [N_PORTS];

  logic [N_PORTS-1:0] addr_mask;
  logic [N_PORTS-1:0] data_mask;
  logic [N_PORTS-1:0] hit;
  logic [N_PORTS-1:0] ar_req;
  logic [N_PORTS-1:0] grant;

  logic              ar_fire;
  logic              beat_fire;
  logic              sel_in_data;
  logic              proto_err;
  logic [3:0]        sel_cnt;
  logic [3:0]        sel_len;
  logic [ADDR_W-1:0] g_addr;
  logic [3:0]        g_len;
  logic [2:0]        g_size;
  logic [ID_W-1:0]   g_id;

  assign arburst = BURST_INCR;
  assign arlock  = '0;
  assign arcache = '0;
  assign arprot  = '0;

  assign ar_fire = arvalid & arready;

  // While an address is outstanding only its owner requests, so the
  // arbiter's grant equals arid and the pointer advances to it.
  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      addr_mask[i] = (state[i] == ST_ADDR);
      data_mask[i] = (state[i] == ST_DATA);
      req_ready[i] = (state[i] == ST_IDLE);
      hit[i]       = (rid == ID_W'(i));
      ar_req[i]    = arvalid ? (arid == ID_W'(i))
                             : addr_mask[i];
    end
  end

  rr_arbiter #(
    .N(N_PORTS)
  ) u_rr (
    .clock   (clock),
    .reset   (reset),
    .req     (ar_req),
    .advance (ar_fire),
    .grant   (grant)
  );

  always_comb begin
    g_addr = '0;
    g_len  = '0;
    g_size = '0;
    g_id   = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (grant[i]) begin
        g_addr = lat_addr[i];
        g_len  = lat_len[i];
        g_size = lat_size[i];
        g_id   = ID_W'(i);
      end
    end
  end

  // R routing is purely combinational; hit is all-zero for an
  // out-of-range rid, which makes such beats unowned.
  always_comb begin
    sel_cnt = '0;
    sel_len = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (hit[i]) begin
        sel_cnt = beat_cnt[i];
        sel_len = lat_len[i];
      end
    end
    sel_in_data = |(hit & data_mask);
    resp_valid  = {N_PORTS{rvalid}} & hit & data_mask;
    resp_data   = rdata;
    resp_last   = rlast;
    rready      = sel_in_data ? |(hit & resp_ready) : 1'b1;
    beat_fire   = rvalid & rready & sel_in_data;
    proto_err   = rlast ? (sel_cnt != sel_len)
                        : (sel_cnt == sel_len);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_PORTS; i++) begin
        state[i]    <= ST_IDLE;
        lat_addr[i] <= '0;
        lat_len[i]  <= '0;
        lat_size[i] <= '0;
        beat_cnt[i] <= '0;
      end
      arvalid   <= 1'b0;
      arid      <= '0;
      araddr    <= '0;
      arlen     <= '0;
      arsize    <= '0;
      err_pulse <= 1'b0;
      err_port  <= '0;
    end else begin
      for (int i = 0; i < N_PORTS; i++) begin
        unique case (state[i])
          ST_IDLE: begin
            if (req_valid[i]) begin
              lat_addr[i] <= req_addr[i*ADDR_W +: ADDR_W];
              lat_len[i]  <= req_len[i*4 +: 4];
              lat_size[i] <= req_size[i*3 +: 3];
              state[i]    <= ST_ADDR;
            end
          end
          ST_ADDR: begin
            if (ar_fire && arid == ID_W'(i)) begin
              beat_cnt[i] <= '0;
              state[i]    <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (beat_fire && hit[i]) begin
              if (rlast) begin
                beat_cnt[i] <= '0;
                state[i]    <= ST_IDLE;
              end else begin
                beat_cnt[i] <= beat_cnt[i] + 4'd1;
              end
            end
          end
          default: state[i] <= ST_IDLE;
        endcase
      end

      // One bubble cycle after each handshake lets the pointer
      // settle before the next grant is sampled.
      if (!arvalid) begin
        if (|grant) begin
          arvalid <= 1'b1;
          arid    <= g_id;
          araddr  <= g_addr;
          arlen   <= g_len;
          arsize  <= g_size;
        end
      end else if (arready) begin
        arvalid <= 1'b0;
      end

      // An owned beat always carries its port index in rid, so
      // err_port is rid for every error class.
      err_pulse <= 1'b0;
      if (rvalid && rready) begin
        if (!sel_in_data || proto_err || rresp != RESP_OKAY) begin
          err_pulse <= 1'b1;
          err_port  <= rid;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed scoreboard bench for axi_read_arbiter (N_PORTS=2).
// AR expectations are queued at request time and popped on handshake.
module tb_axi_read_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_addr;
  logic [7:0]  req_len;
  logic [5:0]  req_size;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [31:0] resp_data;
  logic        resp_last;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic        err_pulse;
  logic [3:0]  err_port;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
  } ar_t;

  ar_t ar_q[$];

  always #5 clock = ~clock;

  axi_read_arbiter #(
    .N_PORTS(2), .ADDR_W(32), .DATA_W(32), .ID_W(4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_len    (req_len),
    .req_size   (req_size),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_last  (resp_last),
    .arid       (arid),
    .araddr     (araddr),
    .arlen      (arlen),
    .arsize     (arsize),
    .arburst    (arburst),
    .arlock     (arlock),
    .arcache    (arcache),
    .arprot     (arprot),
    .arvalid    (arvalid),
    .arready    (arready),
    .rid        (rid),
    .rdata      (rdata),
    .rresp      (rresp),
    .rlast      (rlast),
    .rvalid     (rvalid),
    .rready     (rready),
    .err_pulse  (err_pulse),
    .err_port   (err_port)
  );

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [1:0] mask,
                     input logic [31:0] a0, input logic [31:0] a1,
                     input logic [3:0] l0, input logic [3:0] l1);
    ar_t e;
    @(negedge clock);
    req_valid = mask;
    req_addr  = {a1, a0};
    req_len   = {l1, l0};
    req_size  = {3'd2, 3'd2};
    #1;
    check("req_ready", 64'(req_ready & mask), 64'(mask));
    if (mask[0]) begin
      e.id = 4'd0; e.addr = a0; e.len = l0; e.size = 3'd2;
      ar_q.push_back(e);
    end
    if (mask[1]) begin
      e.id = 4'd1; e.addr = a1; e.len = l1; e.size = 3'd2;
      ar_q.push_back(e);
    end
    @(negedge clock);
    req_valid = '0;
  endtask

  task automatic wait_ar();
    ar_t e;
    bit found;
    found = 1'b0;
    #1;
    for (int c = 0; c < 30 && !found; c++) begin
      if (c > 0) begin
        @(negedge clock);
        #1;
      end
      found = arvalid && arready;
    end
    if (!found) begin
      check("ar_timeout", 64'd0, 64'd1);
    end else if (ar_q.size() == 0) begin
      check("ar_unexpected", 64'd1, 64'd0);
      @(posedge clock);
    end else begin
      e = ar_q.pop_front();
      check("arid",    64'(arid),    64'(e.id));
      check("araddr",  64'(araddr),  64'(e.addr));
      check("arlen",   64'(arlen),   64'(e.len));
      check("arsize",  64'(arsize),  64'(e.size));
      check("arburst", 64'(arburst), 64'd1);
      check("ar_zero", 64'({arlock, arcache, arprot}), 64'd0);
      @(posedge clock);
    end
  endtask

  task automatic beat(input logic [3:0] id, input logic [31:0] d,
                      input logic l, input logic [1:0] rs,
                      input logic [1:0] rr_in,
                      input logic [1:0] exp_v, input logic exp_rr);
    @(negedge clock);
    rvalid     = 1'b1;
    rid        = id;
    rdata      = d;
    rlast      = l;
    rresp      = rs;
    resp_ready = rr_in;
    #1;
    check("resp_valid", 64'(resp_valid), 64'(exp_v));
    check("rready",     64'(rready),     64'(exp_rr));
    if (exp_v != 2'b00) begin
      check("resp_data", 64'(resp_data), 64'(d));
      check("resp_last", 64'(resp_last), 64'(l));
    end
  endtask

  task automatic r_off();
    @(negedge clock);
    rvalid     = 1'b0;
    rlast      = 1'b0;
    rresp      = 2'b00;
    resp_ready = 2'b11;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    req_valid  = '0;
    req_addr   = '0;
    req_len    = '0;
    req_size   = '0;
    resp_ready = 2'b11;
    arready    = 1'b1;
    rid        = '0;
    rdata      = '0;
    rresp      = '0;
    rlast      = 1'b0;
    rvalid     = 1'b0;

    repeat (2) @(negedge clock);
    #1;
    check("rst_req_ready", 64'(req_ready), 64'h3);
    check("rst_arvalid",   64'(arvalid),   64'd0);
    check("rst_err",       64'(err_pulse), 64'd0);
    check("rst_resp_v",    64'(resp_valid), 64'd0);
    @(negedge clock);
    reset = 1'b0;

    // Both ports at once: port 0 first, then port 1, twice.
    for (int r = 0; r < 2; r++) begin
      req(2'b11, 32'h2000 + 32'(r), 32'h3000 + 32'(r), 4'd0, 4'd1);
      #1;
      check("ar_lat_n1", 64'(arvalid), 64'd0);
      @(negedge clock);
      #1;
      check("ar_lat_n2", 64'(arvalid), 64'd1);
      wait_ar();
      wait_ar();
      beat(4'd0, 32'hA000, 1'b1, 2'b00, 2'b11, 2'b01, 1'b1);
      beat(4'd1, 32'hB000, 1'b0, 2'b00, 2'b11, 2'b10, 1'b1);
      beat(4'd1, 32'hB001, 1'b1, 2'b00, 2'b11, 2'b10, 1'b1);
      r_off();
      check("rr_idle", 64'(req_ready), 64'h3);
      check("rr_noerr", 64'(err_pulse), 64'd0);
    end

    // Single 4-beat burst on port 0.
    req(2'b01, 32'h1000, 32'h0, 4'd3, 4'd0);
    wait_ar();
    for (int b = 0; b < 4; b++) begin
      beat(4'd0, 32'h5500 + 32'(b), (b == 3), 2'b00,
           2'b11, 2'b01, 1'b1);
      if (b < 3) begin
        #1;
        check("burst_busy", 64'(req_ready[0]), 64'd0);
      end
    end
    r_off();
    check("burst_idle", 64'(req_ready[0]), 64'd1);
    check("burst_noerr", 64'(err_pulse), 64'd0);

    // Address stall: AR must stay put while arready is low.
    arready = 1'b0;
    req(2'b01, 32'h4000, 32'h0, 4'd0, 4'd0);
    @(negedge clock);
    #1;
    check("stall_arvalid", 64'(arvalid), 64'd1);
    req(2'b10, 32'h0, 32'h5000, 4'd0, 4'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      #1;
      check("stall_araddr", 64'(araddr), 64'h4000);
      check("stall_arid",   64'(arid),   64'd0);
    end
    arready = 1'b1;
    wait_ar();
    wait_ar();

    // Interleaved beats with backpressure on port 1.
    beat(4'd1, 32'hB0, 1'b0, 2'b00, 2'b01, 2'b10, 1'b0);
    beat(4'd1, 32'hB0, 1'b0, 2'b00, 2'b11, 2'b10, 1'b1);
    beat(4'd0, 32'hA0, 1'b1, 2'b00, 2'b11, 2'b01, 1'b1);
    beat(4'd1, 32'hB1, 1'b1, 2'b00, 2'b10, 2'b10, 1'b1);
    r_off();
    check("ilv_idle",  64'(req_ready), 64'h3);
    check("ilv_noerr", 64'(err_pulse), 64'd0);

    // Out-of-range rid: consumed, dropped, flagged.
    beat(4'd5, 32'hDEAD, 1'b1, 2'b00, 2'b11, 2'b00, 1'b1);
    r_off();
    check("rid5_err",  64'(err_pulse), 64'd1);
    check("rid5_port", 64'(err_port),  64'd5);
    @(negedge clock);
    #1;
    check("rid5_pulse1", 64'(err_pulse), 64'd0);

    // Beat for a port that is idle.
    beat(4'd0, 32'hBEEF, 1'b0, 2'b00, 2'b11, 2'b00, 1'b1);
    r_off();
    check("idle_err",  64'(err_pulse), 64'd1);
    check("idle_port", 64'(err_port),  64'd0);

    // Early rlast on the second beat of a len-3 burst.
    req(2'b01, 32'h9000, 32'h0, 4'd3, 4'd0);
    wait_ar();
    beat(4'd0, 32'h90, 1'b0, 2'b00, 2'b11, 2'b01, 1'b1);
    beat(4'd0, 32'h91, 1'b1, 2'b00, 2'b11, 2'b01, 1'b1);
    r_off();
    check("early_err",  64'(err_pulse),    64'd1);
    check("early_port", 64'(err_port),     64'd0);
    check("early_idle", 64'(req_ready[0]), 64'd1);

    // Error response: data still forwarded, error raised.
    req(2'b10, 32'h0, 32'h8000, 4'd0, 4'd0);
    wait_ar();
    beat(4'd1, 32'hCC, 1'b1, 2'b10, 2'b11, 2'b10, 1'b1);
    r_off();
    check("rresp_err",  64'(err_pulse), 64'd1);
    check("rresp_port", 64'(err_port),  64'd1);

    // Reset in the middle of a burst.
    req(2'b01, 32'h7000, 32'h0, 4'd3, 4'd0);
    wait_ar();
    beat(4'd0, 32'hD0, 1'b0, 2'b00, 2'b11, 2'b01, 1'b1);
    @(negedge clock);
    rdata = 32'hD1;
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_arvalid", 64'(arvalid),    64'd0);
    check("mid_rst_ready",   64'(req_ready),  64'h3);
    check("mid_rst_err",     64'(err_pulse),  64'd0);
    check("mid_rst_resp_v",  64'(resp_valid), 64'd0);
    check("mid_rst_rready",  64'(rready),     64'd1);
    @(negedge clock);
    reset  = 1'b0;
    rvalid = 1'b0;
    rlast  = 1'b0;
    req(2'b10, 32'h0, 32'h6000, 4'd0, 4'd0);
    #1;
    check("post_rst_noerr", 64'(err_pulse), 64'd0);
    wait_ar();
    beat(4'd1, 32'hE0, 1'b1, 2'b00, 2'b11, 2'b10, 1'b1);
    r_off();
    check("post_rst_idle",  64'(req_ready), 64'h3);
    check("post_rst_err",   64'(err_pulse), 64'd0);
    check("ar_q_empty",     64'(ar_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_read_arbiter.md
AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

Interface
REQ-001 SHALL have parameter N_PORTS, default 2, number of read requesters (1..8).
REQ-002 SHALL have parameter ADDR_W, default 32, address width.
REQ-003 SHALL have parameter DATA_W, default 32, data width.
REQ-004 SHALL have parameter ID_W, default 4, AXI id width; 2^ID_W >= N_PORTS.
REQ-005 SHALL have port clock, input, 1, sole clock; all logic on rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have ports req_valid, input, N_PORTS, and req_ready, output, N_PORTS: per-port request handshake.
REQ-008 SHALL have ports req_addr, input, N_PORTS*ADDR_W; req_len, input, N_PORTS*4; req_size, input, N_PORTS*3: per-port packed request fields.
REQ-009 SHALL have ports resp_valid, output, N_PORTS; resp_ready, input, N_PORTS; resp_data, output, DATA_W (shared); resp_last, output, 1: response channel.
REQ-010 SHALL have AXI AR master ports arid ID_W, araddr ADDR_W, arlen 4, arsize 3, arburst 2, arlock 2, arcache 4, arprot 3, arvalid 1 (outputs) and arready 1 (input).
REQ-011 SHALL have AXI R ports rid ID_W, rdata DATA_W, rresp 2, rlast 1, rvalid 1 (inputs) and rready 1 (output).
REQ-012 SHALL have output err_pulse, 1, single-cycle error indication, and err_port, ID_W, id associated with the error.

Function
REQ-013 Each port SHALL own a 3-state FSM: IDLE, ADDR, DATA.
REQ-014 IDLE: req_ready[i]=1; req_valid[i]&req_ready[i] latches addr/len/size into port registers, moves to ADDR next cycle.
REQ-015 ADDR: port competes for AR; granted port drives ar* from its latched registers; on arvalid&arready move to DATA.
REQ-016 DATA: port accepts beats with rid==i; on beat with rlast accepted, return to IDLE next cycle; new request accepted only in IDLE (max one outstanding per port).
REQ-017 AR arbitration SHALL be round-robin among ports in ADDR, starting search at (last_granted+1) mod N_PORTS; pointer updates only on AR handshake.
REQ-018 Grant SHALL be held stable while arvalid=1 and arready=0 (AXI: no address/id change while valid).
REQ-019 arid SHALL equal granted port index, zero-extended; arburst=2'b01 (INCR); arlock, arcache, arprot =0.
REQ-020 arvalid SHALL be registered; AR issue latency: request accepted cycle N, arvalid earliest cycle N+2.
REQ-021 R routing: resp_valid[i]=rvalid&(rid==i); resp_data=rdata; resp_last=rlast; rready=resp_ready[rid] when rid<N_PORTS and that port in DATA; combinational, zero latency.
REQ-022 Beat with rid>=N_PORTS or to a port not in DATA SHALL be consumed (rready=1), dropped, and raise err_pulse with err_port=rid.
REQ-023 Per-port 4-bit beat counter SHALL count accepted beats; rlast on beat != latched len, or beat==len without rlast, SHALL raise err_pulse with err_port=port; port returns to IDLE only on rlast.
REQ-024 rresp!=0 on accepted beat SHALL raise err_pulse; data still forwarded.
REQ-025 Simultaneous: AR handshake for port A and last R beat for port B in same cycle SHALL both take effect; a port completing rlast may accept a new request the following cycle.
REQ-026 Only one err_pulse per cycle; priority REQ-022 > REQ-023 > REQ-024.

Reset
REQ-027 On reset all FSMs IDLE, counters 0, RR pointer N_PORTS-1 (first grant port 0), arvalid=0, err_pulse=0, latched fields 0.
REQ-028 Reset mid-transaction SHALL abandon outstanding bursts immediately; post-reset stray R beats handled per REQ-022.
REQ-029 Outputs req_ready SHALL be all-ones in reset since all ports IDLE.

Structure
REQ-030 Shared package SHALL hold FSM state enum, AXI burst/resp constants (INCR, OKAY), and max port count.
REQ-031 Round-robin arbiter SHALL be one sub-module rr_arbiter (N-wide request, grant one-hot, advance enable).

Verification
REQ-032 Port0 req addr 0x1000 len 3 -> arid 0, araddr 0x1000, arlen 3 issued; 4 beats rid 0 delivered, resp_last on 4th, port0 IDLE next cycle.
REQ-033 Ports 0,1 request same cycle, arready=1 -> grants 0 then 1; repeat -> RR pointer alternates 0,1.
REQ-034 arready held 0 for 5 cycles while port1 requests later -> araddr/arid unchanged until handshake.
REQ-035 Interleaved R beats rid 1, 0, 1 -> each routed to correct port, rready follows that port's resp_ready backpressure.
REQ-036 rid 5 with N_PORTS=2 -> beat consumed, err_pulse=1 one cycle, err_port=5; rlast on beat 2 of len 3 -> err_pulse, err_port=port.
REQ-037 Reset asserted during port0 DATA beat 1 -> all outputs reset values same cycle; next request proceeds normally.
